// File: rtl/if_id_skid_pkg.sv
// Shared definitions for the IF/ID skid register: default bus widths, reset level,
// reset/NOP words and the 2-bit occupancy state encoding.
package if_id_skid_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INST_W = 32;

  localparam logic        RST_ENABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFID_EMPTY = 2'd0,
    IFID_BUSY  = 2'd1,
    IFID_FULL  = 2'd2
  } ifid_state_e;

  // Fetch may only be accepted while the skid slot is free.
  function automatic logic state_accepts(input ifid_state_e s);
    return (s != IFID_FULL);
  endfunction

endpackage

// File: rtl/ifid_perf_cnt.sv
// Saturating stall/flush event counters for the IF/ID register; this module only
// exists in builds with IFID_PERF_CNT_EN defined.
`ifdef IFID_PERF_CNT_EN
module ifid_perf_cnt
  import if_id_skid_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_evt,
  input  logic        flush_evt,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a 2-entry skid (main + skid slot), registered if_ready
// and synchronous flush. Optional perf counters under IFID_PERF_CNT_EN.
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [1:0]        dbg_state
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  // Handshake: a side transfers on a rising edge where its valid and ready are both 1.
  // if_ready is a flop (high unless the skid slot holds data); id_valid/id_pc/id_inst are flops.

  ifid_state_e       state_q, state_d;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic              id_valid_q, id_valid_d;
  logic              if_ready_q, if_ready_d;
  logic              in_xfer, out_xfer;

  assign in_xfer  = if_valid & if_ready_q;
  assign out_xfer = id_valid_q & id_ready;

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;

    if (flush) begin
      // Redirect: drop everything held and incoming; a coincident output transfer
      // has already been taken by decode, so nothing else is needed for it.
      state_d     = IFID_EMPTY;
      main_pc_d   = ADDR_W'(ZERO_WORD);
      main_inst_d = NOP_INST;
    end else begin
      case (state_q)
        IFID_EMPTY: begin
          if (in_xfer) begin
            main_pc_d   = if_pc;
            main_inst_d = if_inst;
            state_d     = IFID_BUSY;
          end
        end
        IFID_BUSY: begin
          if (in_xfer && out_xfer) begin
            main_pc_d   = if_pc;
            main_inst_d = if_inst;
          end else if (in_xfer) begin
            skid_pc_d   = if_pc;
            skid_inst_d = if_inst;
            state_d     = IFID_FULL;
          end else if (out_xfer) begin
            state_d     = IFID_EMPTY;
          end
        end
        IFID_FULL: begin
          if (out_xfer) begin
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
            state_d     = IFID_BUSY;
          end
        end
        default: state_d = IFID_EMPTY;
      endcase
    end

    id_valid_d = (state_d != IFID_EMPTY);
    if_ready_d = state_accepts(state_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q     <= IFID_EMPTY;
      main_pc_q   <= ADDR_W'(ZERO_WORD);
      main_inst_q <= NOP_INST;
      skid_pc_q   <= ADDR_W'(ZERO_WORD);
      skid_inst_q <= NOP_INST;
      id_valid_q  <= 1'b0;
      if_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      id_valid_q  <= id_valid_d;
      if_ready_q  <= if_ready_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = main_pc_q;
  assign id_inst   = main_inst_q;
  assign dbg_state = state_q;

`ifdef IFID_PERF_CNT_EN
  ifid_perf_cnt u_perf_cnt (
    .clk       (clk),
    .rst       (rst),
    .stall_evt (id_valid_q & ~id_ready),
    .flush_evt (flush),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench for if_id_skid: directed scenarios plus random backpressure,
// checked against a 2-deep FIFO model of the fetch->decode path.
module tb_if_id_skid;

  localparam int          W   = 64;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [1:0]  dbg_state;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  int unsigned stall_m;
  int unsigned flush_m;
`endif

  if_id_skid dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .dbg_state (dbg_state)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];      // instructions held by the block, oldest first
  logic [W-1:0] last_out;      // last instruction consumed by decode
  logic         clean;         // outputs should show 0 / NOP when empty
  logic         acc_now;       // driver accepted an item this cycle (not yet in DUT)
  int           checks;
  int           errors;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One call = one clock cycle. Acceptance is decided by the model: the block takes
  // a new instruction whenever it holds fewer than two.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic idr, input logic fl);
    @(posedge clk);
    #1;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = idr;
    flush    = fl;
    #2;
    if (v && (exp_q.size() < 2) && !fl && rst) begin
      exp_q.push_back({pc, inst});
      acc_now = 1'b1;
    end
  endtask

  task automatic reset_mid_cycle();
    @(posedge clk);
    #4;
    rst = 1'b0;
    exp_q.delete();
    acc_now = 1'b0;
    clean   = 1'b1;
`ifdef IFID_PERF_CNT_EN
    stall_m = 0;
    flush_m = 0;
`endif
    #1;
    check("async_rst_valid", W'(id_valid), W'(1'b0));
    check("async_rst_ready", W'(if_ready), W'(1'b1));
    check("async_rst_pc", W'(id_pc), W'(32'h0));
    check("async_rst_inst", W'(id_inst), W'(NOP));
    if_valid = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    int occ;
    forever begin
      @(posedge clk);
      #7;
      occ = exp_q.size() - (acc_now ? 1 : 0);
      check("id_valid", W'(id_valid), W'(occ != 0));
      check("if_ready", W'(if_ready), W'(occ != 2));
      check("dbg_state", W'(dbg_state), W'(occ));
      if (occ != 0)
        check("id_slot", {id_pc, id_inst}, exp_q[0]);
      else if (clean)
        check("id_slot_clean", {id_pc, id_inst}, {32'h0, NOP});
      else
        check("id_slot_hold", {id_pc, id_inst}, last_out);
`ifdef IFID_PERF_CNT_EN
      check("stall_cnt", W'(stall_cnt), W'(stall_m));
      check("flush_cnt", W'(flush_cnt), W'(flush_m));
      if (rst && occ != 0 && !id_ready && stall_m != 32'hFFFF_FFFF) stall_m++;
      if (rst && flush && flush_m != 16'hFFFF) flush_m++;
`endif
      if (rst && occ != 0 && id_ready) begin
        last_out = exp_q.pop_front();
        clean    = 1'b0;
      end
      if (rst && flush) begin
        exp_q.delete();
        clean = 1'b1;
      end
      acc_now = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  logic        cur_v;
  logic [31:0] cur_pc;
  logic [31:0] cur_inst;
  logic [31:0] next_pc;
  logic        pending;

  initial begin
    checks   = 0;
    errors   = 0;
    clean    = 1'b1;
    acc_now  = 1'b0;
    last_out = '0;
`ifdef IFID_PERF_CNT_EN
    stall_m  = 0;
    flush_m  = 0;
`endif
    flush    = 1'b0;
    if_valid = 1'b0;
    if_pc    = '0;
    if_inst  = '0;
    id_ready = 1'b0;
    rst      = 1'b1;
    #1 rst   = 1'b0;
    #2;
    check("rst_valid", W'(id_valid), W'(1'b0));
    check("rst_ready", W'(if_ready), W'(1'b1));
    check("rst_pc", W'(id_pc), W'(32'h0));
    check("rst_inst", W'(id_inst), W'(NOP));
    check("rst_state", W'(dbg_state), W'(2'd0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Streaming with decode always ready
    drive(1'b1, 32'h0, 32'hA000_0000, 1'b1, 1'b0);
    drive(1'b1, 32'h4, 32'hA000_0004, 1'b1, 1'b0);
    drive(1'b1, 32'h8, 32'hA000_0008, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Stall into the skid slot, then release
    drive(1'b1, 32'h10, 32'hB000_0010, 1'b0, 1'b0);
    drive(1'b1, 32'h14, 32'hB000_0014, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush while FULL with a third instruction offered
    drive(1'b1, 32'h20, 32'hC000_0020, 1'b0, 1'b0);
    drive(1'b1, 32'h24, 32'hC000_0024, 1'b0, 1'b0);
    drive(1'b1, 32'h28, 32'hC000_0028, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush coincident with an output and an input transfer
    drive(1'b1, 32'h2C, 32'hC000_002C, 1'b1, 1'b0);
    drive(1'b1, 32'h40, 32'hC000_0040, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset while FULL, then stream again
    drive(1'b1, 32'h50, 32'hD000_0050, 1'b0, 1'b0);
    drive(1'b1, 32'h54, 32'hD000_0054, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset_mid_cycle();
    drive(1'b1, 32'h30, 32'hE000_0030, 1'b1, 1'b0);
    drive(1'b1, 32'h34, 32'hE000_0034, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic; fetch holds an offered instruction until it is taken
    next_pc = 32'h1000;
    pending = 1'b0;
    cur_v   = 1'b0;
    cur_pc  = '0;
    cur_inst = '0;
    for (int i = 0; i < 1000; i++) begin
      logic idr;
      logic fl;
      if (!pending) begin
        cur_v    = ($urandom_range(0, 3) != 0);
        cur_pc   = next_pc;
        cur_inst = $urandom;
      end
      idr = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      drive(cur_v, cur_pc, cur_inst, idr, fl);
      pending = cur_v && !acc_now && !fl;
      if (acc_now) next_pc = next_pc + 32'd4;
    end

    repeat (4) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #8;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Parametrised next-generation IF/ID pipeline register between the fetch and decode stages.
- Carries PC and instruction with a valid/ready handshake, so decode can stall fetch without losing instructions.
- Includes a 2-entry skid buffer, which gives full throughput with a registered `if_ready`.
- Supports synchronous flush for branch and exception redirect; flushed slots present a NOP.

Parameters:
- ADDR_W, 32, PC width in bits.
- INST_W, 32, instruction width in bits.
- NOP_INST, 32'h0000_0000, instruction value driven when the output slot is empty or flushed.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset (asserted when 0).
- flush  in  1  synchronous flush; discards all held and incoming instructions.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  block can accept; registered.
- if_pc  in  ADDR_W  fetch PC.
- if_inst  in  INST_W  fetch instruction.
- id_valid  out  1  decode slot holds an instruction.
- id_ready  in  1  decode accepts this cycle.
- id_pc  out  ADDR_W  PC to decode; registered.
- id_inst  out  INST_W  instruction to decode; registered.

Behaviour:
- Reset (rst=0, asynchronous): id_valid=0, id_pc=0, id_inst=NOP_INST, if_ready=1, skid entry invalid, state EMPTY. Reset may occur mid-transfer; all contents are lost.
- Transfers: input transfer = if_valid & if_ready; output transfer = id_valid & id_ready.
- Latency is 1 cycle: an instruction accepted at edge N appears on id_* after edge N.
- With id_ready held at 1, throughput is one instruction per cycle.
- States:
  - EMPTY: main slot empty, skid slot empty.
  - BUSY: main slot full, skid slot empty.
  - FULL: main slot full, skid slot full.
- Transitions:
  - EMPTY: input transfer -> load main, go to BUSY.
  - BUSY, input and output transfer together: main <= input, stay in BUSY.
  - BUSY, input only with id_ready=0: input goes to the skid slot, go to FULL, if_ready<=0.
  - BUSY, output only: go to EMPTY; id_pc/id_inst keep their last value while id_valid=0.
  - FULL, id_ready=1: main <= skid, go to BUSY, if_ready<=1.
  - FULL: no input transfer is possible because if_ready=0.
- if_ready is registered and equals ~skid_valid. The fetch stage must hold if_pc/if_inst stable while if_valid=1 and if_ready=0.
- Flush has priority over every other event:
  - Next cycle: id_valid=0, id_inst=NOP_INST, id_pc=0, skid invalid, if_ready=1, state EMPTY.
  - An input transfer coincident with flush is discarded.
  - An output transfer coincident with flush still completes (decode consumed it).
- id_valid=0 always shows id_inst=NOP_INST after reset or flush. When id_valid=0 after a normal drain, the last value is held.
- Widths are passed straight through; no arithmetic.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- Defined: adds outputs stall_cnt (32 bits) and flush_cnt (16 bits).
  - stall_cnt increments each cycle with id_valid & ~id_ready.
  - flush_cnt increments each cycle flush=1.
  - Both saturate at their maximum value and are reset to 0 by rst.
- Undefined: the ports and logic are absent; the core behaviour is identical.

Decomposition:
- Shared define file holds:
  - bus macros InstAddrBus and InstBus, derived from ADDR_W/INST_W defaults;
  - ZeroWord and NopInst;
  - RstEnable = 1'b0 for this block;
  - 2-bit state encodings IFID_EMPTY, IFID_BUSY, IFID_FULL.
- One sub-module is natural: ifid_perf_cnt, a saturating counter pair instantiated only under IFID_PERF_CNT_EN.
- The skid logic stays inline.

Test Plan:
- Streaming: reset, then id_ready=1 with if_valid=1 and PCs 0x0, 0x4, 0x8 -> id_pc = 0x0, 0x4, 0x8 on consecutive cycles, id_valid=1, if_ready stays 1.
- Stall: PC 0x10 accepted, id_ready=0, PC 0x14 accepted -> next cycle if_ready=0 and id_pc holds 0x10. Then id_ready=1 -> 0x10 consumed, next id_pc=0x14, if_ready=1, no loss or duplication.
- Flush while FULL: flush=1 with 0x20 in main, 0x24 in skid, and 0x28 offered -> next cycle id_valid=0, id_inst=NOP_INST, id_pc=0, if_ready=1. 0x28 never appears.
- Asynchronous reset mid-stall: drop rst between clock edges while FULL -> outputs reach reset values immediately without a clock edge. After release, PC 0x30 streams normally.
- Random backpressure: 1000 cycles of random if_valid/id_ready -> decode-side PC sequence equals fetch-side accepted sequence, and if_ready=0 only in FULL.
- With IFID_PERF_CNT_EN defined: 5 stalled cycles plus 2 flush pulses -> stall_cnt=5, flush_cnt=2. Saturation: flush_cnt preloaded to 0xFFFF stays at 0xFFFF.
